// File: rtl/magic_ctl.sv
// magic_ctl: multi-source NMI entry, magic ROM/RAM map sequencing and a config register bank.
// Define MAGIC_READBACK_EN to enable config/cause readback on the config I/O port.
module magic_ctl #(
    parameter int                        SRC_COUNT    = 2,
    parameter int                        CFG_REGS     = 16,
    parameter int                        CFG_W        = 8,
    parameter logic [CFG_REGS*CFG_W-1:0] CFG_RESET    = '0,
    parameter logic [15:0]               ENTRY_ADDR   = 16'h0066,
    parameter logic [15:0]               EXIT_ADDR    = 16'hf000,
    parameter logic [15:0]               REENTER_ADDR = 16'hf008,
    parameter logic [7:0]                CFG_PORT     = 8'hff,
    parameter int                        NMI_TIMEOUT  = 1024
) (
    input  logic                        clk28,
    input  logic                        rst_n,
    input  logic [15:0]                 bus_a,
    input  logic [7:0]                  bus_d,
    input  logic                        bus_memreq,
    input  logic                        bus_ioreq,
    input  logic                        bus_rd,
    input  logic                        bus_wr,
    input  logic                        bus_m1,
    input  logic                        n_int,
    input  logic                        n_int_next,
    input  logic [SRC_COUNT-1:0]        trig,
    output logic                        n_nmi,
    output logic                        magic_mode,
    output logic                        magic_map,
    output logic [SRC_COUNT-1:0]        cause,
    output logic [CFG_REGS*CFG_W-1:0]   cfg,
    output logic [CFG_REGS-1:0]         cfg_wr_stb,
    output logic [7:0]                  dout,
    output logic                        dout_active
);

    localparam int         CNT_W      = $clog2(NMI_TIMEOUT + 1);
    localparam logic [8:0] CFG_REGS_W = 9'(CFG_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NMI,
        ST_MAPPED,
        ST_UNMAP,
        ST_REMAP
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 n_nmi_nx;
    logic                 mode_nx;
    logic                 map_nx;
    logic                 remap_flag;
    logic                 remap_nx;
    logic [SRC_COUNT-1:0] cause_nx;
    logic [SRC_COUNT-1:0] pending;
    logic [SRC_COUNT-1:0] pending_nx;
    logic [SRC_COUNT-1:0] trig_p0;
    logic [SRC_COUNT-1:0] trig_rise;
    logic [SRC_COUNT-1:0] pend_all;
    logic [SRC_COUNT-1:0] pick;
    logic [CNT_W-1:0]     nmi_cnt;
    logic [CNT_W-1:0]     cnt_nx;

    logic                 frame_edge;
    logic                 entry_fetch;
    logic                 mem_rd;
    logic [7:0]           cfg_idx;
    logic                 port_hit;
    logic                 wr_hit;
    logic [CFG_W-1:0]     wr_data;

    function automatic logic [SRC_COUNT-1:0] lowest_bit(input logic [SRC_COUNT-1:0] v);
        return v & (~v + SRC_COUNT'(1));
    endfunction

    assign trig_rise   = trig & ~trig_p0;
    assign pend_all    = pending | trig_rise;
    assign pick        = lowest_bit(pend_all);
    assign frame_edge  = n_int && !n_int_next;
    assign entry_fetch = bus_m1 && bus_memreq && (bus_a == ENTRY_ADDR);
    assign mem_rd      = bus_memreq && bus_rd;

    assign cfg_idx  = bus_a[15:8];
    assign port_hit = magic_map && bus_ioreq && (bus_a[7:0] == CFG_PORT);
    assign wr_hit   = port_hit && bus_wr && ({1'b0, cfg_idx} < CFG_REGS_W);
    assign wr_data  = bus_d[CFG_W-1:0];

    always_comb begin
        state_nx   = state;
        n_nmi_nx   = n_nmi;
        mode_nx    = magic_mode;
        map_nx     = magic_map;
        cause_nx   = cause;
        remap_nx   = remap_flag;
        pending_nx = pend_all;
        cnt_nx     = nmi_cnt;
        case (state)
            ST_IDLE: begin
                // A trigger edge landing on the frame edge itself is already in pend_all.
                if (frame_edge && (pend_all != '0)) begin
                    state_nx   = ST_NMI;
                    n_nmi_nx   = 1'b0;
                    mode_nx    = 1'b1;
                    cause_nx   = pick;
                    pending_nx = pend_all & ~pick;
                    cnt_nx     = '0;
                end
            end
            ST_NMI: begin
                if (entry_fetch) begin
                    state_nx = ST_MAPPED;
                    n_nmi_nx = 1'b1;
                    map_nx   = 1'b1;
                end else if (nmi_cnt == CNT_W'(NMI_TIMEOUT - 1)) begin
                    state_nx = ST_IDLE;
                    n_nmi_nx = 1'b1;
                    mode_nx  = 1'b0;
                end else begin
                    cnt_nx = nmi_cnt + CNT_W'(1);
                end
            end
            ST_MAPPED: begin
                if (mem_rd && (bus_a == EXIT_ADDR)) begin
                    state_nx = ST_UNMAP;
                    mode_nx  = 1'b0;
                    remap_nx = 1'b0;
                end else if (mem_rd && (bus_a == REENTER_ADDR)) begin
                    state_nx = ST_UNMAP;
                    remap_nx = 1'b1;
                end
            end
            ST_UNMAP: begin
                // Keep the map until the exiting read has finished on the bus.
                if (!bus_memreq) begin
                    map_nx   = 1'b0;
                    state_nx = remap_flag ? ST_REMAP : ST_IDLE;
                end
            end
            ST_REMAP: begin
                if (bus_m1 && bus_memreq) begin
                    state_nx = ST_MAPPED;
                    map_nx   = 1'b1;
                    remap_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_MAPPED;
            n_nmi      <= 1'b1;
            magic_mode <= 1'b1;
            magic_map  <= 1'b1;
            cause      <= '0;
            remap_flag <= 1'b0;
            pending    <= '0;
            trig_p0    <= '0;
            nmi_cnt    <= '0;
        end else begin
            state      <= state_nx;
            n_nmi      <= n_nmi_nx;
            magic_mode <= mode_nx;
            magic_map  <= map_nx;
            cause      <= cause_nx;
            remap_flag <= remap_nx;
            pending    <= pending_nx;
            trig_p0    <= trig;
            nmi_cnt    <= cnt_nx;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cfg        <= CFG_RESET;
            cfg_wr_stb <= '0;
        end else begin
            // Register 0 bit 0 is a reboot request: it falls back unless rewritten.
            cfg[0] <= CFG_RESET[0];
            for (int i = 0; i < CFG_REGS; i++) begin
                cfg_wr_stb[i] <= wr_hit && (cfg_idx == 8'(i));
                if (wr_hit && (cfg_idx == 8'(i)))
                    cfg[i*CFG_W +: CFG_W] <= wr_data;
            end
        end
    end

`ifdef MAGIC_READBACK_EN
    logic       rd_reg_hit;
    logic       rd_cause_hit;
    logic [7:0] rd_data;

    assign rd_reg_hit   = port_hit && bus_rd && ({1'b0, cfg_idx} < CFG_REGS_W);
    assign rd_cause_hit = port_hit && bus_rd && (CFG_REGS < 256) &&
                          ({1'b0, cfg_idx} == CFG_REGS_W);

    always_comb begin
        rd_data = '0;
        if (rd_cause_hit) begin
            rd_data = 8'(cause) << (8 - SRC_COUNT);
        end else begin
            for (int i = 0; i < CFG_REGS; i++) begin
                if (cfg_idx == 8'(i))
                    rd_data = 8'(cfg[i*CFG_W +: CFG_W]);
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= '0;
            dout_active <= 1'b0;
        end else begin
            dout        <= (rd_reg_hit || rd_cause_hit) ? rd_data : 8'h00;
            dout_active <= rd_reg_hit || rd_cause_hit;
        end
    end
`else
    assign dout        = 8'h00;
    assign dout_active = 1'b0;
`endif

endmodule

// File: tb/tb_magic_ctl.sv
// Directed bench for magic_ctl: reset, session sequencing, timeout, remap and config bank.
module tb_magic_ctl;

    localparam logic [127:0] CFG_INIT = {112'd0, 8'hA5, 8'h00};

    logic         clk28 = 1'b0;
    logic         rst_n;
    logic [15:0]  bus_a;
    logic [7:0]   bus_d;
    logic         bus_memreq, bus_ioreq, bus_rd, bus_wr, bus_m1;
    logic         n_int, n_int_next;
    logic [1:0]   trig;
    logic         n_nmi, magic_mode, magic_map;
    logic [1:0]   cause;
    logic [127:0] cfg;
    logic [15:0]  cfg_wr_stb;
    logic [7:0]   dout;
    logic         dout_active;

    int vectors    = 0;
    int miscompares = 0;

    magic_ctl #(.CFG_RESET(CFG_INIT)) dut (
        .clk28(clk28), .rst_n(rst_n), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_m1(bus_m1), .n_int(n_int), .n_int_next(n_int_next),
        .trig(trig), .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
        .cause(cause), .cfg(cfg), .cfg_wr_stb(cfg_wr_stb), .dout(dout),
        .dout_active(dout_active)
    );

    always #5 clk28 = ~clk28;

    function automatic logic [7:0] reg_val(input int i);
        return cfg[i*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_clear();
        bus_memreq = 0; bus_ioreq = 0; bus_rd = 0; bus_wr = 0; bus_m1 = 0;
        bus_a = 16'h0000; bus_d = 8'h00;
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic m1);
        bus_a = a; bus_memreq = 1; bus_rd = 1; bus_m1 = m1;
        tick();
        bus_clear();
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        bus_a = a; bus_d = d; bus_ioreq = 1; bus_wr = 1;
        tick();
        bus_clear();
    endtask

    task automatic frame();
        n_int_next = 0;
        tick();
        n_int_next = 1;
    endtask

    task automatic pulse_trig(input logic [1:0] t);
        trig = t;
        tick();
        trig = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; trig = 0; n_int = 1; n_int_next = 1;
        bus_clear();
        repeat (3) tick();
        vectors++; if (n_nmi !== 1'b1) begin miscompares++; $display("FAIL reset_n_nmi got %b want 1", n_nmi); end
        vectors++; if ({magic_mode, magic_map} !== 2'b11) begin miscompares++; $display("FAIL reset_mode_map got %b want 11", {magic_mode, magic_map}); end
        vectors++; if (cause !== 2'b00) begin miscompares++; $display("FAIL reset_cause got %b want 00", cause); end
        vectors++; if (cfg !== CFG_INIT) begin miscompares++; $display("FAIL reset_cfg got %h want %h", cfg, CFG_INIT); end
        vectors++; if ({cfg_wr_stb, dout, dout_active} !== 25'd0) begin miscompares++; $display("FAIL reset_stb_dout got %h/%h/%b want 0", cfg_wr_stb, dout, dout_active); end
        rst_n = 1;
        tick();
        vectors++; if ({n_nmi, magic_mode, magic_map} !== 3'b111) begin miscompares++; $display("FAIL post_reset got %b want 111", {n_nmi, magic_mode, magic_map}); end
    endtask

    task automatic test_cfg_write();
        io_write(16'h03FF, 8'h02);
        vectors++; if (reg_val(3) !== 8'h02) begin miscompares++; $display("FAIL cfg_reg3 got %h want 02", reg_val(3)); end
        vectors++; if (cfg_wr_stb !== 16'h0008) begin miscompares++; $display("FAIL cfg_stb3 got %h want 0008", cfg_wr_stb); end
        tick();
        vectors++; if (cfg_wr_stb !== 16'h0000) begin miscompares++; $display("FAIL cfg_stb_clear got %h want 0000", cfg_wr_stb); end
        io_write(16'h03FF, 8'h02);
        vectors++; if (cfg_wr_stb !== 16'h0008) begin miscompares++; $display("FAIL cfg_stb_same got %h want 0008", cfg_wr_stb); end
        io_write(16'h10FF, 8'hAA);
        vectors++; if (cfg_wr_stb !== 16'h0000 || cfg[127:32] !== CFG_INIT[127:32]) begin miscompares++; $display("FAIL cfg_idx_range got stb %h cfg %h want no write", cfg_wr_stb, cfg); end
        io_write(16'h03FE, 8'h55);
        vectors++; if (cfg_wr_stb !== 16'h0000 || reg_val(3) !== 8'h02) begin miscompares++; $display("FAIL cfg_port got stb %h reg3 %h want 0000/02", cfg_wr_stb, reg_val(3)); end
        io_write(16'h00FF, 8'h03);
        vectors++; if (reg_val(0) !== 8'h03 || cfg_wr_stb !== 16'h0001) begin miscompares++; $display("FAIL cfg_reg0 got %h stb %h want 03/0001", reg_val(0), cfg_wr_stb); end
        tick();
        vectors++; if (reg_val(0) !== 8'h02) begin miscompares++; $display("FAIL cfg_selfclr got %h want 02", reg_val(0)); end
        vectors++; if (reg_val(1) !== 8'hA5) begin miscompares++; $display("FAIL cfg_reg1 got %h want a5", reg_val(1)); end
        bus_a = 16'h03FF; bus_ioreq = 1; bus_rd = 1;
        tick();
`ifdef MAGIC_READBACK_EN
        vectors++; if ({dout_active, dout} !== 9'h102) begin miscompares++; $display("FAIL readback got %b/%h want 1/02", dout_active, dout); end
`else
        vectors++; if ({dout_active, dout} !== 9'h000) begin miscompares++; $display("FAIL readback_off got %b/%h want 0/00", dout_active, dout); end
`endif
        bus_clear();
        tick();
        vectors++; if (dout_active !== 1'b0) begin miscompares++; $display("FAIL readback_release got %b want 0", dout_active); end
    endtask

    task automatic test_exit();
        bus_a = 16'hF000; bus_memreq = 1; bus_rd = 1;
        tick();
        vectors++; if ({magic_mode, magic_map} !== 2'b01) begin miscompares++; $display("FAIL exit_read got %b want 01", {magic_mode, magic_map}); end
        bus_rd = 0; bus_a = 16'h0001;
        tick();
        vectors++; if (magic_map !== 1'b1) begin miscompares++; $display("FAIL exit_hold got %b want 1", magic_map); end
        bus_clear();
        tick();
        vectors++; if ({magic_mode, magic_map} !== 2'b00) begin miscompares++; $display("FAIL exit_unmap got %b want 00", {magic_mode, magic_map}); end
        frame();
        vectors++; if (n_nmi !== 1'b1) begin miscompares++; $display("FAIL idle_no_pending got %b want 1", n_nmi); end
        io_write(16'h03FF, 8'h55);
        vectors++; if (cfg_wr_stb !== 16'h0000 || reg_val(3) !== 8'h02) begin miscompares++; $display("FAIL cfg_unmapped got stb %h reg3 %h want 0000/02", cfg_wr_stb, reg_val(3)); end
    endtask

    task automatic test_nmi_single();
        pulse_trig(2'b10);
        frame();
        vectors++; if ({n_nmi, magic_mode, magic_map} !== 3'b010) begin miscompares++; $display("FAIL nmi1_start got %b want 010", {n_nmi, magic_mode, magic_map}); end
        vectors++; if (cause !== 2'b10) begin miscompares++; $display("FAIL nmi1_cause got %b want 10", cause); end
        bus_cycle(16'h0066, 1'b1);
        vectors++; if ({n_nmi, magic_map} !== 2'b11) begin miscompares++; $display("FAIL nmi1_entry got %b want 11", {n_nmi, magic_map}); end
        bus_a = 16'h10FF; bus_ioreq = 1; bus_rd = 1;
        tick();
`ifdef MAGIC_READBACK_EN
        vectors++; if ({dout_active, dout} !== 9'h180) begin miscompares++; $display("FAIL readback_cause got %b/%h want 1/80", dout_active, dout); end
`else
        vectors++; if ({dout_active, dout} !== 9'h000) begin miscompares++; $display("FAIL readback_cause_off got %b/%h want 0/00", dout_active, dout); end
`endif
        bus_clear();
        bus_cycle(16'hF000, 1'b0);
        tick();
        vectors++; if ({magic_mode, magic_map} !== 2'b00) begin miscompares++; $display("FAIL nmi1_exit got %b want 00", {magic_mode, magic_map}); end
    endtask

    task automatic test_priority_timeout();
        logic early;
        pulse_trig(2'b11);
        frame();
        vectors++; if ({n_nmi, cause} !== 3'b001) begin miscompares++; $display("FAIL prio_first got n_nmi %b cause %b want 0/01", n_nmi, cause); end
        bus_cycle(16'h0066, 1'b1);
        bus_cycle(16'hF000, 1'b0);
        tick();
        frame();
        vectors++; if ({n_nmi, cause} !== 3'b010) begin miscompares++; $display("FAIL prio_second got n_nmi %b cause %b want 0/10", n_nmi, cause); end
        early = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            tick();
            if (n_nmi !== 1'b0) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL timeout_early got released want held 1024 cycles"); end
        tick();
        vectors++; if ({n_nmi, magic_mode, cause} !== 4'b1010) begin miscompares++; $display("FAIL timeout got n_nmi %b mode %b cause %b want 1/0/10", n_nmi, magic_mode, cause); end
        bus_cycle(16'h0066, 1'b1);
        vectors++; if ({n_nmi, magic_map} !== 2'b10) begin miscompares++; $display("FAIL timeout_idle got %b want 10", {n_nmi, magic_map}); end
    endtask

    task automatic test_back_to_back();
        trig = 2'b01; n_int_next = 0;
        tick();
        n_int_next = 1; trig = 2'b00;
        vectors++; if ({n_nmi, cause} !== 3'b001) begin miscompares++; $display("FAIL coincident got n_nmi %b cause %b want 0/01", n_nmi, cause); end
        bus_cycle(16'h0066, 1'b1);
        pulse_trig(2'b10);
        frame();
        vectors++; if ({n_nmi, cause} !== 3'b101) begin miscompares++; $display("FAIL no_nest got n_nmi %b cause %b want 1/01", n_nmi, cause); end
        bus_cycle(16'hF008, 1'b0);
        vectors++; if ({magic_mode, magic_map} !== 2'b11) begin miscompares++; $display("FAIL reenter_read got %b want 11", {magic_mode, magic_map}); end
        tick();
        vectors++; if ({magic_mode, magic_map} !== 2'b10) begin miscompares++; $display("FAIL reenter_unmap got %b want 10", {magic_mode, magic_map}); end
        bus_cycle(16'h8000, 1'b0);
        vectors++; if (magic_map !== 1'b0) begin miscompares++; $display("FAIL remap_non_m1 got %b want 0", magic_map); end
        bus_cycle(16'h8000, 1'b1);
        vectors++; if ({magic_mode, magic_map} !== 2'b11) begin miscompares++; $display("FAIL remap_m1 got %b want 11", {magic_mode, magic_map}); end
        bus_cycle(16'hF000, 1'b0);
        tick();
        frame();
        vectors++; if ({n_nmi, cause} !== 3'b010) begin miscompares++; $display("FAIL held_pending got n_nmi %b cause %b want 0/10", n_nmi, cause); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 0;
        #1;
        vectors++; if ({n_nmi, magic_mode, magic_map, cause} !== 5'b11100) begin miscompares++; $display("FAIL async_rst got %b want 11100", {n_nmi, magic_mode, magic_map, cause}); end
        vectors++; if (cfg !== CFG_INIT || cfg_wr_stb !== 16'h0000) begin miscompares++; $display("FAIL async_rst_cfg got %h/%h want %h/0000", cfg, cfg_wr_stb, CFG_INIT); end
        tick();
        rst_n = 1;
        tick();
        vectors++; if ({n_nmi, magic_mode, magic_map} !== 3'b111) begin miscompares++; $display("FAIL async_rst_release got %b want 111", {n_nmi, magic_mode, magic_map}); end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_exit();
        test_nmi_single();
        test_priority_timeout();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
